uart_tx_fifo: RTL and testbench

Byte buffer between the host-side write interface and the uart_top transmit inputs. It accepts bytes at up to one per clock and stores them in a circular FIFO. It drains the FIFO into the UART transmitter by issuing one-cycle tx_start pulses with tx_data held stable, handling one byte at a time. It tracks tx_busy so each byte is started exactly once and never while the transmitter is busy.

---
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_top: buffers host writes and hands bytes to the transmitter
// one at a time with a tx_start pulse, then follows tx_busy (with a timeout) before the next pop.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_e        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          wr_ok, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  // A pop is only launched from IDLE so each byte gets exactly one start pulse.
  assign wr_ok = wr_en && !full;
  assign pop   = (state_q == IDLE) && !empty && !tx_busy;

  // Next-state and registered-output logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    overflow_d = wr_en && full;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          state_d    = WAIT_BUSY;
          tmo_d      = '0;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never raises busy must not stall the queue forever.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents after reset are irrelevant since count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4) with a selectable tx_busy responder
// that records every started byte and the cycle it started in.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int M_HOLD   = 0;
  localparam int M_UART   = 1;
  localparam int M_NORESP = 2;
  localparam logic [7:0] HELLO [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         mode     = M_HOLD;
  logic       hold_val = 1'b0;
  int         cyc;
  logic [7:0] rx_q [$];
  int         rx_cyc [$];
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  // Transmitter stand-in: runs just after each falling edge, after the main sequence has set mode.
  initial begin : busy_model
    int   bcnt;
    logic prev_start;
    bcnt       = 0;
    prev_start = 1'b0;
    tx_busy    = 1'b0;
    cyc        = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (tx_start) begin
        rx_q.push_back(tx_data);
        rx_cyc.push_back(cyc);
        check_eq("start_while_busy", 32'(tx_busy), 32'h0);
        check_eq("start_width", 32'(prev_start), 32'h0);
      end
      prev_start = tx_start;
      case (mode)
        M_HOLD:   tx_busy = hold_val;
        M_UART: begin
          if (tx_start) bcnt = 4;
          else if (bcnt > 0) bcnt--;
          tx_busy = (bcnt != 0);
        end
        default:  tx_busy = 1'b0;
      endcase
    end
  end

  initial begin : main_seq
    int w;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tick(2);
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_empty", 32'(empty), 32'h1);
    check_eq("rst_full", 32'(full), 32'h0);
    check_eq("rst_tx_start", 32'(tx_start), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // Single byte: one pulse, two edges after the write.
    mode = M_UART;
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h41;
    tick(1);
    wr_en = 1'b0;
    check_eq("t1_count1", 32'(count), 32'h1);
    check_eq("t1_no_start_yet", 32'(tx_start), 32'h0);
    tick(1);
    check_eq("t1_start", 32'(tx_start), 32'h1);
    check_eq("t1_data", 32'(tx_data), 32'h41);
    check_eq("t1_count0", 32'(count), 32'h0);
    tick(1);
    check_eq("t1_start_low", 32'(tx_start), 32'h0);
    tick(12);
    exp_q.push_back(8'h41);
    check_rx("t1_rx");
    check_eq("t1_empty", 32'(empty), 32'h1);

    // Fill while busy is held; fifth write overflows.
    mode = M_HOLD; hold_val = 1'b1;
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = HELLO[i];
      tick(1);
      check_eq($sformatf("t2_ovf%0d", i), 32'(overflow), (i == 4) ? 32'h1 : 32'h0);
    end
    wr_en = 1'b0;
    check_eq("t2_count", 32'(count), 32'h4);
    check_eq("t2_full", 32'(full), 32'h1);
    tick(1);
    check_eq("t2_ovf_clear", 32'(overflow), 32'h0);
    check_eq("t2_no_start", 32'(rx_q.size()), 32'h0);
    mode = M_UART;
    tick(40);
    for (int i = 0; i < 4; i++) exp_q.push_back(HELLO[i]);
    check_rx("t2_rx");
    check_eq("t2_empty", 32'(empty), 32'h1);

    // Unresponsive transmitter: timeout releases the handshake, next byte 9 cycles later.
    mode = M_NORESP;
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h11;
    tick(1);
    wr_data = 8'h22;
    tick(1);
    wr_en = 1'b0;
    tick(40);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_rx("t3_rx");
    if (rx_cyc.size() == 2) check_eq("t3_gap", 32'(rx_cyc[1] - rx_cyc[0]), 32'd9);
    check_eq("t3_empty", 32'(empty), 32'h1);

    // Full FIFO: write rejected despite a same-cycle pop; later write+pop holds count.
    mode = M_HOLD; hold_val = 1'b1;
    clear_rx();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      tick(1);
    end
    check_eq("t4_full", 32'(full), 32'h1);
    hold_val = 1'b0; wr_en = 1'b1; wr_data = 8'hA4;
    tick(1);
    check_eq("t4_ovf", 32'(overflow), 32'h1);
    check_eq("t4_count3", 32'(count), 32'h3);
    check_eq("t4_start", 32'(tx_start), 32'h1);
    check_eq("t4_data", 32'(tx_data), 32'hA0);
    hold_val = 1'b1; wr_en = 1'b0;
    tick(1);
    check_eq("t4_ovf_clear", 32'(overflow), 32'h0);
    hold_val = 1'b0;
    tick(1);
    check_eq("t4_count_hold", 32'(count), 32'h3);
    wr_en = 1'b1; wr_data = 8'hA5;
    tick(1);
    wr_en = 1'b0;
    mode = M_UART;
    check_eq("t4_wr_pop_count", 32'(count), 32'h3);
    check_eq("t4_start2", 32'(tx_start), 32'h1);
    check_eq("t4_data2", 32'(tx_data), 32'hA1);
    check_eq("t4_no_ovf", 32'(overflow), 32'h0);
    tick(50);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA5);
    check_rx("t4_rx");

    // Stream ten bytes through the 4-entry ring.
    clear_rx();
    for (int i = 0; i < 10; i++) begin
      w = 0;
      while (full && w < 50) begin
        tick(1);
        w++;
      end
      check_eq($sformatf("t5_room%0d", i), 32'(full), 32'h0);
      wr_en = 1'b1; wr_data = 8'(i);
      tick(1);
      wr_en = 1'b0;
      exp_q.push_back(8'(i));
    end
    tick(100);
    check_rx("t5_rx");
    check_eq("t5_empty", 32'(empty), 32'h1);

    // Reset in WAIT_DONE with three bytes queued.
    mode = M_HOLD; hold_val = 1'b0;
    clear_rx();
    wr_en = 1'b1; wr_data = 8'hB0;
    tick(1);
    wr_data = 8'hB1;
    tick(1);
    check_eq("t6_start", 32'(tx_start), 32'h1);
    check_eq("t6_data", 32'(tx_data), 32'hB0);
    hold_val = 1'b1; wr_data = 8'hB2;
    tick(1);
    wr_data = 8'hB3;
    tick(1);
    check_eq("t6_count3", 32'(count), 32'h3);
    wr_en = 1'b0; rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_eq("t6_count", 32'(count), 32'h0);
    check_eq("t6_empty", 32'(empty), 32'h1);
    check_eq("t6_tx_start", 32'(tx_start), 32'h0);
    check_eq("t6_tx_data", 32'(tx_data), 32'h0);
    clear_rx();
    hold_val = 1'b0;
    tick(20);
    check_eq("t6_no_start", 32'(rx_q.size()), 32'h0);
    wr_en = 1'b1; wr_data = 8'hC7;
    tick(1);
    wr_en = 1'b0;
    tick(15);
    exp_q.push_back(8'hC7);
    check_rx("t6_rx");
    check_eq("t6_final_empty", 32'(empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
